// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU issue/writeback sequencer: opcodes, flag bit
// positions, data width and FSM state encoding.
package alu_seq_pkg;

   localparam int DW = 10;
   localparam int FW = 4;

   localparam logic [2:0] ADD  = 3'd0;
   localparam logic [2:0] SUB  = 3'd1;
   localparam logic [2:0] MAX  = 3'd2;
   localparam logic [2:0] MIN  = 3'd3;
   localparam logic [2:0] AND  = 3'd4;
   localparam logic [2:0] ORR  = 3'd5;
   localparam logic [2:0] XOR  = 3'd6;
   localparam logic [2:0] XNOR = 3'd7;

   localparam int NEG  = 3;
   localparam int POS  = 2;
   localparam int ZERO = 1;
   localparam int OVF  = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      WB   = 2'd2
   } state_t;

   // AND with immediate zero is the instruction that clears a sticky overflow.
   function automatic logic is_ovf_clear(input logic [2:0] oper, input logic imm,
                                         input logic signed [DW-1:0] data);
      return (oper == AND) && imm && (data == '0);
   endfunction

endpackage

// File: rtl/alu_regfile.sv
// NREGS x DW register array: synchronous active-low reset, one write port,
// three combinational read ports (two operand reads and one debug read).
module alu_regfile
   import alu_seq_pkg::*;
#(
   parameter int NREGS = 8,
   localparam int AW = $clog2(NREGS)
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_we,
   input  logic [AW-1:0]        i_waddr,
   input  logic signed [DW-1:0] i_wdata,
   input  logic [AW-1:0]        i_raddr0,
   input  logic [AW-1:0]        i_raddr1,
   input  logic [AW-1:0]        i_raddr2,
   output logic signed [DW-1:0] o_rdata0,
   output logic signed [DW-1:0] o_rdata1,
   output logic signed [DW-1:0] o_rdata2
);

   logic signed [DW-1:0] regs [NREGS];

   // Register array: cleared on reset, single write per cycle otherwise.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         regs <= '{default: '0};
      end else if (i_we) begin
         regs[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata0 = regs[i_raddr0];
   assign o_rdata1 = regs[i_raddr1];
   assign o_rdata2 = regs[i_raddr2];

endmodule

// File: rtl/alu_issue_wb.sv
// Issue/writeback sequencer around an external combinational ALU.
// IDLE -> EXEC -> WB, one instruction per three cycles. Operands are read
// from the register file at accept, so dst == src needs no hazard handling.
// Optional feature: define ALU_ISSUE_STICKY_OVF_EN to make o_flag[0] sticky.
module alu_issue_wb
   import alu_seq_pkg::*;
#(
   parameter int NREGS = 8,
   localparam int AW = $clog2(NREGS)
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  logic [2:0]           i_oper,
   input  logic                 i_imm,
   input  logic signed [DW-1:0] i_data,
   input  logic [AW-1:0]        i_src0,
   input  logic [AW-1:0]        i_src1,
   input  logic [AW-1:0]        i_dst,
   output logic signed [DW-1:0] o_alu_data,
   output logic signed [DW-1:0] o_alu_arg0,
   output logic signed [DW-1:0] o_alu_arg1,
   output logic [2:0]           o_alu_oper,
   output logic                 o_alu_imm,
   input  logic signed [DW-1:0] i_alu_result,
   input  logic [FW-1:0]        i_alu_flag,
   output logic [FW-1:0]        o_flag,
   output logic                 o_done,
   input  logic [AW-1:0]        i_rd_addr,
   output logic signed [DW-1:0] o_rd_data
);

   state_t               state_q, state_d;
   logic                 accept;
   logic                 wb_en;
   logic [AW-1:0]        dst_q;
   logic signed [DW-1:0] rd_src0, rd_src1;

   alu_regfile #(.NREGS(NREGS)) u_regfile (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_we     (wb_en),
      .i_waddr  (dst_q),
      .i_wdata  (i_alu_result),
      .i_raddr0 (i_src0),
      .i_raddr1 (i_src1),
      .i_raddr2 (i_rd_addr),
      .o_rdata0 (rd_src0),
      .o_rdata1 (rd_src1),
      .o_rdata2 (o_rd_data)
   );

   // Next-state and handshake/commit strobes; reset gates ready and done.
   always_comb begin
      state_d = state_q;
      o_ready = 1'b0;
      accept  = 1'b0;
      wb_en   = 1'b0;
      case (state_q)
         IDLE: begin
            o_ready = i_rst_n;
            accept  = i_valid && i_rst_n;
            if (accept) state_d = EXEC;
         end
         EXEC: state_d = WB;
         WB: begin
            wb_en   = i_rst_n;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign o_done = wb_en;

   // State register.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Issue registers: capture instruction fields and pre-writeback operands at accept.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         o_alu_data <= '0;
         o_alu_arg0 <= '0;
         o_alu_arg1 <= '0;
         o_alu_oper <= '0;
         o_alu_imm  <= 1'b0;
         dst_q      <= '0;
      end else if (accept) begin
         o_alu_data <= i_data;
         o_alu_arg0 <= rd_src0;
         o_alu_arg1 <= rd_src1;
         o_alu_oper <= i_oper;
         o_alu_imm  <= i_imm;
         dst_q      <= i_dst;
      end
   end

`ifdef ALU_ISSUE_STICKY_OVF_EN
   // Flag register with sticky overflow: WB ORs into bit 0 (OVF is bit 0),
   // and an accepted AND-with-immediate-zero clears it.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         o_flag <= '0;
      end else if (wb_en) begin
         o_flag <= {i_alu_flag[FW-1:1], i_alu_flag[OVF] | o_flag[OVF]};
      end else if (accept && is_ovf_clear(i_oper, i_imm, i_data)) begin
         o_flag[OVF] <= 1'b0;
      end
   end
`else
   // Flag register: plain copy of the ALU flags at writeback.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n)   o_flag <= '0;
      else if (wb_en) o_flag <= i_alu_flag;
   end
`endif

endmodule

// File: tb/tb_alu_issue_wb.sv
// Directed testbench for alu_issue_wb with a behavioural model of the 10-bit ALU.
// Define ALU_ISSUE_STICKY_OVF_EN to also exercise the sticky overflow flag.
module tb_alu_issue_wb;

   logic              clk;
   logic              rst_n;
   logic              valid;
   logic              ready;
   logic [2:0]        oper;
   logic              imm;
   logic signed [9:0] data;
   logic [2:0]        src0, src1, dst;
   logic signed [9:0] alu_data, alu_arg0, alu_arg1;
   logic [2:0]        alu_oper;
   logic              alu_imm;
   logic signed [9:0] alu_result;
   logic [3:0]        alu_flag;
   logic [3:0]        flag;
   logic              done;
   logic [2:0]        rd_addr;
   logic signed [9:0] rd_data;

   int n_checks = 0;
   int n_fail   = 0;

   alu_issue_wb #(.NREGS(8)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_valid      (valid),
      .o_ready      (ready),
      .i_oper       (oper),
      .i_imm        (imm),
      .i_data       (data),
      .i_src0       (src0),
      .i_src1       (src1),
      .i_dst        (dst),
      .o_alu_data   (alu_data),
      .o_alu_arg0   (alu_arg0),
      .o_alu_arg1   (alu_arg1),
      .o_alu_oper   (alu_oper),
      .o_alu_imm    (alu_imm),
      .i_alu_result (alu_result),
      .i_alu_flag   (alu_flag),
      .o_flag       (flag),
      .o_done       (done),
      .i_rd_addr    (rd_addr),
      .o_rd_data    (rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural 10-bit ALU, flags ordered {NEG,POS,ZERO,OVF}.
   logic signed [9:0] ma, mb, mr;
   logic              movf;
   always_comb begin
      ma   = alu_imm ? alu_data : alu_arg0;
      mb   = alu_arg1;
      mr   = '0;
      movf = 1'b0;
      case (alu_oper)
         3'd0: begin mr = ma + mb; movf = (ma[9] == mb[9]) && (mr[9] != ma[9]); end
         3'd1: begin mr = ma - mb; movf = (ma[9] != mb[9]) && (mr[9] != ma[9]); end
         3'd2: mr = (ma > mb) ? ma : mb;
         3'd3: mr = (ma < mb) ? ma : mb;
         3'd4: mr = ma & mb;
         3'd5: mr = ma | mb;
         3'd6: mr = ma ^ mb;
         default: mr = ~(ma ^ mb);
      endcase
      alu_result = mr;
      alu_flag   = {mr[9], !mr[9] && (mr != 0), mr == 0, movf};
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic read_reg(input logic [2:0] a, input logic signed [9:0] exp, input string tag);
      rd_addr = a;
      #1;
      chk(tag, rd_data, exp);
   endtask

   // Issue one instruction from IDLE, follow it through EXEC and WB, then check
   // operands, done timing, written register and flags.
   task automatic issue(input string tag, input logic [2:0] op, input logic im,
                        input logic signed [9:0] d, input logic [2:0] s0, input logic [2:0] s1,
                        input logic [2:0] ds, input logic signed [9:0] exp_a0,
                        input logic signed [9:0] exp_a1, input logic signed [9:0] exp_res,
                        input logic [3:0] exp_flag);
      oper = op; imm = im; data = d; src0 = s0; src1 = s1; dst = ds; valid = 1'b1;
      chk({tag, " ready"}, ready, 1);
      tick();
      valid = 1'b0;
      chk({tag, " done_exec"}, done, 0);
      chk({tag, " ready_exec"}, ready, 0);
      chk({tag, " arg0"}, alu_arg0, exp_a0);
      chk({tag, " arg1"}, alu_arg1, exp_a1);
      chk({tag, " oper"}, alu_oper, op);
      chk({tag, " data"}, alu_data, d);
      tick();
      chk({tag, " done_wb"}, done, 1);
      tick();
      chk({tag, " done_idle"}, done, 0);
      read_reg(ds, exp_res, {tag, " result"});
      chk({tag, " flag"}, flag, exp_flag);
   endtask

   int accepts;
   int pat [7] = '{1, 0, 0, 1, 0, 0, 1};

   initial begin
      rst_n = 1'b0; valid = 1'b0; oper = '0; imm = 1'b0; data = '0;
      src0 = '0; src1 = '0; dst = '0; rd_addr = '0;

      // Reset state
      tick(); tick();
      chk("rst ready", ready, 0);
      chk("rst done", done, 0);
      chk("rst flag", flag, 0);
      chk("rst arg0", alu_arg0, 0);
      read_reg(3'd3, 10'sd0, "rst r3");
      rst_n = 1'b1;
      #1;
      chk("rel ready", ready, 1);
      tick();

      // ADD overflow: 300 + 300 wraps to -424
      issue("ld r1", 3'd0, 1'b1, 10'sd300, 3'd0, 3'd0, 3'd1, 10'sd0, 10'sd0, 10'sd300, 4'b0100);
      issue("ld r2", 3'd0, 1'b1, 10'sd300, 3'd0, 3'd0, 3'd2, 10'sd0, 10'sd0, 10'sd300, 4'b0100);
      issue("add ovf", 3'd0, 1'b0, 10'sd0, 3'd1, 3'd2, 3'd3, 10'sd300, 10'sd300, -10'sd424, 4'b1001);

      // Reset during WB of ADD imm 7 -> r2
      oper = 3'd0; imm = 1'b1; data = 10'sd7; src0 = 3'd0; src1 = 3'd0; dst = 3'd2; valid = 1'b1;
      tick();
      valid = 1'b0;
      tick();
      chk("rwb done_pre", done, 1);
      rst_n = 1'b0;
      #1;
      chk("rwb done_rst", done, 0);
      chk("rwb ready_rst", ready, 0);
      tick();
      chk("rwb done_after", done, 0);
      chk("rwb flag", flag, 0);
      chk("rwb alu_data", alu_data, 0);
      read_reg(3'd2, 10'sd0, "rwb r2");
      read_reg(3'd1, 10'sd0, "rwb r1");
      rst_n = 1'b1;
      tick();
      chk("rwb ready_rel", ready, 1);
      chk("rwb done_rel", done, 0);

      // SUB zero
      issue("ld r4", 3'd0, 1'b1, 10'sd5, 3'd0, 3'd0, 3'd4, 10'sd0, 10'sd0, 10'sd5, 4'b0100);
      issue("sub zero", 3'd1, 1'b0, 10'sd0, 3'd4, 3'd4, 3'd5, 10'sd5, 10'sd5, 10'sd0, 4'b0010);

      // Immediate MAX
      issue("ld r1b", 3'd0, 1'b1, 10'sd3, 3'd0, 3'd0, 3'd1, 10'sd0, 10'sd0, 10'sd3, 4'b0100);
      issue("max imm", 3'd2, 1'b1, -10'sd7, 3'd0, 3'd1, 3'd6, 10'sd0, 10'sd3, 10'sd3, 4'b0100);
      chk("max imm_hold", alu_imm, 1);
      chk("max data_hold", alu_data, -7);

      // dst == src0: r1 = r1 - r4 = 3 - 5
      issue("sub hazard", 3'd1, 1'b0, 10'sd0, 3'd1, 3'd4, 3'd1, 10'sd3, 10'sd5, -10'sd2, 4'b1000);

      // Backpressure: valid held for 7 cycles
      accepts = 0;
      oper = 3'd0; imm = 1'b1; data = 10'sd10; src0 = 3'd0; src1 = 3'd0; dst = 3'd7; valid = 1'b1;
      for (int c = 0; c < 7; c++) begin
         if (c == 1) begin oper = 3'd0; imm = 1'b0; data = 10'sd0; src0 = 3'd7; src1 = 3'd7; dst = 3'd7; end
         if (c == 4) begin oper = 3'd5; imm = 1'b1; data = 10'sd1; src0 = 3'd0; src1 = 3'd7; dst = 3'd2; end
         chk($sformatf("bp ready c%0d", c), ready, pat[c]);
         if (ready && valid) accepts++;
         tick();
      end
      valid = 1'b0;
      tick();
      tick();
      chk("bp accepts", accepts, 3);
      read_reg(3'd7, 10'sd20, "bp r7");
      read_reg(3'd2, 10'sd21, "bp r2");
      chk("bp flag", flag, 4'b0100);
      tick();

`ifdef ALU_ISSUE_STICKY_OVF_EN
      // Sticky overflow: set by ADD, held through SUB, cleared by AND imm 0
      issue("st ld r1", 3'd0, 1'b1, 10'sd300, 3'd0, 3'd0, 3'd1, 10'sd0, 10'sd0, 10'sd300, 4'b0100);
      issue("st ld r2", 3'd0, 1'b1, 10'sd300, 3'd0, 3'd0, 3'd2, 10'sd0, 10'sd0, 10'sd300, 4'b0100);
      issue("st add", 3'd0, 1'b0, 10'sd0, 3'd1, 3'd2, 3'd3, 10'sd300, 10'sd300, -10'sd424, 4'b1001);
      issue("st ld r4", 3'd0, 1'b1, 10'sd5, 3'd0, 3'd0, 3'd4, 10'sd0, 10'sd0, 10'sd5, 4'b0101);
      issue("st sub", 3'd1, 1'b0, 10'sd0, 3'd4, 3'd4, 3'd5, 10'sd5, 10'sd5, 10'sd0, 4'b0011);
      issue("st and", 3'd4, 1'b1, 10'sd0, 3'd0, 3'd4, 3'd6, 10'sd0, 10'sd5, 10'sd0, 4'b0010);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
